// File: rtl/rs_select_n_if.sv
// rs_select_n_if: dispatch, wakeup, control and issue signals of the
// reservation station, bundled as one interface.
//   master : the surrounding pipeline (drives dispatch/CDB/control, sees issue)
//   slave  : the reservation station itself
// Per-lane / per-slot / per-channel fields are packed flat, lane k in bits
// [k*W +: W].
interface rs_select_n_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 3,
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned CDB_W      = 3,
    parameter int unsigned PR_W       = 6,
    parameter int unsigned PAYLOAD_W  = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DISPATCH_W-1:0]           disp_valid;
    logic [DISPATCH_W*PR_W-1:0]      disp_dest_pr;
    logic [DISPATCH_W*PR_W-1:0]      disp_src1_pr;
    logic [DISPATCH_W*PR_W-1:0]      disp_src2_pr;
    logic [DISPATCH_W-1:0]           disp_src1_ready;
    logic [DISPATCH_W-1:0]           disp_src2_ready;
    logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload;
    logic [CDB_W-1:0]                cdb_valid;
    logic [CDB_W*PR_W-1:0]           cdb_tag;
    logic                            issue_stall;
    logic                            squash;
    logic [ISSUE_W-1:0]              issue_valid;
    logic [ISSUE_W*PR_W-1:0]         issue_dest_pr;
    logic [ISSUE_W*PR_W-1:0]         issue_src1_pr;
    logic [ISSUE_W*PR_W-1:0]         issue_src2_pr;
    logic [ISSUE_W*PAYLOAD_W-1:0]    issue_payload;
    logic [DISPATCH_W-1:0]           struct_stall;
    logic [CNT_W-1:0]                free_count;

    modport master (
        output disp_valid, disp_dest_pr, disp_src1_pr, disp_src2_pr,
               disp_src1_ready, disp_src2_ready, disp_payload,
               cdb_valid, cdb_tag, issue_stall, squash,
        input  issue_valid, issue_dest_pr, issue_src1_pr, issue_src2_pr,
               issue_payload, struct_stall, free_count
    );

    modport slave (
        input  disp_valid, disp_dest_pr, disp_src1_pr, disp_src2_pr,
               disp_src1_ready, disp_src2_ready, disp_payload,
               cdb_valid, cdb_tag, issue_stall, squash,
        output issue_valid, issue_dest_pr, issue_src1_pr, issue_src2_pr,
               issue_payload, struct_stall, free_count
    );
endinterface

// File: rtl/rs_select_n.sv
// rs_select_n: reservation station with oldest-first select.
// Holds up to DEPTH renamed instructions until both sources are ready,
// waking them from CDB_W broadcast tags, and issues up to ISSUE_W eligible
// entries per cycle, oldest in slot 0.
// Ports:
//   clock  : single clock, all state on posedge
//   reset  : synchronous, active-high; empties the station and clears ages
//   bus    : rs_select_n_if slave modport (dispatch lanes, CDB, issue_stall,
//            squash, issue slots, struct_stall, free_count)
module rs_select_n #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 3,
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned CDB_W      = 3,
    parameter int unsigned PR_W       = 6,
    parameter int unsigned PAYLOAD_W  = 64
) (
    input  logic         clock,
    input  logic         reset,
    rs_select_n_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned LANE_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    // Entry state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdy1_q, rdy1_d;
    logic [DEPTH-1:0]     rdy2_q, rdy2_d;
    logic [PR_W-1:0]      dest_q [DEPTH];
    logic [PR_W-1:0]      dest_d [DEPTH];
    logic [PR_W-1:0]      src1_q [DEPTH];
    logic [PR_W-1:0]      src1_d [DEPTH];
    logic [PR_W-1:0]      src2_q [DEPTH];
    logic [PR_W-1:0]      src2_d [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    // older_q[i][j] = 1 when entry i was allocated before entry j.
    // Only meaningful between valid entries.
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];
    logic [CNT_W-1:0]     free_q, free_d;

    function automatic logic cdb_hit(input logic [CDB_W-1:0]      v,
                                     input logic [CDB_W*PR_W-1:0] tags,
                                     input logic [PR_W-1:0]       tag);
        logic hit;
        hit = 1'b0;
        for (int unsigned c = 0; c < CDB_W; c++) begin
            if (v[c] && (tags[c*PR_W +: PR_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Structural stall: the F oldest lanes (highest indices) are open,
    // from registered free count only.
    logic [DISPATCH_W-1:0] stall;
    always_comb begin
        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
            stall[k] = (k + 32'(free_q)) < DISPATCH_W;
        end
    end

    // Allocation: oldest lane first into the lowest free entry.
    logic [DEPTH-1:0]  new_en;
    logic [LANE_W-1:0] new_lane [DEPTH];
    always_comb begin
        logic [DEPTH-1:0] taken;
        logic             placed;
        int unsigned      k;
        new_en = '0;
        for (int unsigned e = 0; e < DEPTH; e++) new_lane[e] = '0;
        taken  = valid_q;
        placed = 1'b0;
        k      = 0;
        for (int unsigned n = 0; n < DISPATCH_W; n++) begin
            k      = DISPATCH_W - 1 - n;
            placed = 1'b0;
            if (bus.disp_valid[k] && !stall[k]) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (!placed && !taken[e]) begin
                        placed      = 1'b1;
                        taken[e]    = 1'b1;
                        new_en[e]   = 1'b1;
                        new_lane[e] = LANE_W'(k);
                    end
                end
            end
        end
    end

    // Select: an eligible entry's rank is the number of older eligible
    // entries; rank r < ISSUE_W drives slot r.
    logic [DEPTH-1:0] elig;
    logic [CNT_W-1:0] rank [DEPTH];
    logic [DEPTH-1:0] issued;
    logic             issue_ok;

    assign issue_ok = !bus.issue_stall && !bus.squash && !reset;

    always_comb begin
        elig = valid_q & rdy1_q & rdy2_q;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            rank[e] = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (elig[j] && older_q[j][e]) rank[e] = rank[e] + CNT_W'(1);
            end
            issued[e] = issue_ok && elig[e] && (rank[e] < CNT_W'(ISSUE_W));
        end
    end

    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W*PR_W-1:0]      iss_dest;
    logic [ISSUE_W*PR_W-1:0]      iss_src1;
    logic [ISSUE_W*PR_W-1:0]      iss_src2;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload;

    always_comb begin
        iss_valid   = '0;
        iss_dest    = '0;
        iss_src1    = '0;
        iss_src2    = '0;
        iss_payload = '0;
        for (int unsigned s = 0; s < ISSUE_W; s++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (issued[e] && (rank[e] == CNT_W'(s))) begin
                    iss_valid[s]                         = 1'b1;
                    iss_dest[s*PR_W +: PR_W]             = dest_q[e];
                    iss_src1[s*PR_W +: PR_W]             = src1_q[e];
                    iss_src2[s*PR_W +: PR_W]             = src2_q[e];
                    iss_payload[s*PAYLOAD_W +: PAYLOAD_W] = payload_q[e];
                end
            end
        end
    end

    // Next state: dispatch writes, wakeup, frees, squash.
    always_comb begin
        int unsigned      l;
        logic [PR_W-1:0]  s1;
        logic [PR_W-1:0]  s2;
        logic [CNT_W-1:0] used;
        valid_d   = valid_q;
        rdy1_d    = rdy1_q;
        rdy2_d    = rdy2_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        payload_d = payload_q;
        older_d   = older_q;
        l         = 0;
        s1        = '0;
        s2        = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (new_en[e]) begin
                l            = 32'(new_lane[e]);
                s1           = bus.disp_src1_pr[l*PR_W +: PR_W];
                s2           = bus.disp_src2_pr[l*PR_W +: PR_W];
                valid_d[e]   = 1'b1;
                dest_d[e]    = bus.disp_dest_pr[l*PR_W +: PR_W];
                src1_d[e]    = s1;
                src2_d[e]    = s2;
                payload_d[e] = bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                rdy1_d[e]    = bus.disp_src1_ready[l] || (s1 == '0) ||
                               cdb_hit(bus.cdb_valid, bus.cdb_tag, s1);
                rdy2_d[e]    = bus.disp_src2_ready[l] || (s2 == '0) ||
                               cdb_hit(bus.cdb_valid, bus.cdb_tag, s2);
                // New entries are younger than all residents; within the
                // same dispatch group the higher lane is older.
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (new_en[j]) begin
                        older_d[e][j] = new_lane[e] > new_lane[j];
                        older_d[j][e] = new_lane[j] > new_lane[e];
                    end else begin
                        older_d[e][j] = 1'b0;
                        older_d[j][e] = 1'b1;
                    end
                end
            end else begin
                if (issued[e]) valid_d[e] = 1'b0;
                rdy1_d[e] = rdy1_q[e] || cdb_hit(bus.cdb_valid, bus.cdb_tag, src1_q[e]);
                rdy2_d[e] = rdy2_q[e] || cdb_hit(bus.cdb_valid, bus.cdb_tag, src2_q[e]);
            end
        end
        if (bus.squash) valid_d = '0;
        used = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (valid_d[e]) used = used + CNT_W'(1);
        end
        free_d = CNT_W'(DEPTH) - used;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            free_q  <= CNT_W'(DEPTH);
            for (int unsigned e = 0; e < DEPTH; e++) older_q[e] <= '0;
        end else begin
            valid_q <= valid_d;
            free_q  <= free_d;
            older_q <= older_d;
        end
    end

    // Entry contents are qualified by valid_q and need no reset.
    always_ff @(posedge clock) begin
        rdy1_q    <= rdy1_d;
        rdy2_q    <= rdy2_d;
        dest_q    <= dest_d;
        src1_q    <= src1_d;
        src2_q    <= src2_d;
        payload_q <= payload_d;
    end

    assign bus.issue_valid   = iss_valid;
    assign bus.issue_dest_pr = iss_dest;
    assign bus.issue_src1_pr = iss_src1;
    assign bus.issue_src2_pr = iss_src2;
    assign bus.issue_payload = iss_payload;
    assign bus.struct_stall  = stall;
    assign bus.free_count    = free_q;
endmodule

// File: tb/tb_rs_select_n.sv
// tb_rs_select_n: directed bench for rs_select_n. Stimulus pushes each
// expected issue (cycle, slot, payload, dest) into a scoreboard queue; a
// monitor on the falling edge pops and compares every valid issue slot.
// Registered outputs (free_count, struct_stall) are checked inline.
module tb_rs_select_n;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned DISPATCH_W = 3;
    localparam int unsigned ISSUE_W    = 2;
    localparam int unsigned CDB_W      = 3;
    localparam int unsigned PR_W       = 6;
    localparam int unsigned PAYLOAD_W  = 64;

    typedef struct {
        int unsigned    cyc;
        int unsigned    slot;
        logic [63:0]    pl;
        logic [PR_W-1:0] dest;
    } exp_t;

    logic        clock;
    logic        reset;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb [$];
    exp_t        got_e;

    rs_select_n_if #(
        .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .ISSUE_W(ISSUE_W),
        .CDB_W(CDB_W), .PR_W(PR_W), .PAYLOAD_W(PAYLOAD_W)
    ) bus ();

    rs_select_n #(
        .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .ISSUE_W(ISSUE_W),
        .CDB_W(CDB_W), .PR_W(PR_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic idle();
        bus.disp_valid      = '0;
        bus.disp_dest_pr    = '0;
        bus.disp_src1_pr    = '0;
        bus.disp_src2_pr    = '0;
        bus.disp_src1_ready = '0;
        bus.disp_src2_ready = '0;
        bus.disp_payload    = '0;
        bus.cdb_valid       = '0;
        bus.cdb_tag         = '0;
        bus.issue_stall     = 1'b0;
        bus.squash          = 1'b0;
    endtask

    task automatic lane(input int unsigned k, input logic [PR_W-1:0] dest,
                        input logic [PR_W-1:0] s1, input logic r1,
                        input logic [PR_W-1:0] s2, input logic r2,
                        input logic [63:0] pl);
        bus.disp_valid[k]                          = 1'b1;
        bus.disp_dest_pr[k*PR_W +: PR_W]           = dest;
        bus.disp_src1_pr[k*PR_W +: PR_W]           = s1;
        bus.disp_src2_pr[k*PR_W +: PR_W]           = s2;
        bus.disp_src1_ready[k]                     = r1;
        bus.disp_src2_ready[k]                     = r2;
        bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl;
    endtask

    task automatic cdb(input int unsigned c, input logic [PR_W-1:0] tag);
        bus.cdb_valid[c]             = 1'b1;
        bus.cdb_tag[c*PR_W +: PR_W]  = tag;
    endtask

    task automatic push(input int unsigned c, input int unsigned s,
                        input logic [63:0] pl, input logic [PR_W-1:0] dest);
        exp_t e;
        e.cyc  = c;
        e.slot = s;
        e.pl   = pl;
        e.dest = dest;
        sb.push_back(e);
    endtask

    // Advance to the next cycle; inputs return to idle right after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    // Monitor: every valid slot must match the head of the scoreboard.
    always @(negedge clock) begin
        for (int s = 0; s < int'(ISSUE_W); s++) begin
            if (bus.issue_valid[s]) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected cyc=%0d slot=%0d got pl=%0h want none",
                             cyc, s, bus.issue_payload[s*PAYLOAD_W +: PAYLOAD_W]);
                end else begin
                    got_e = sb.pop_front();
                    if (got_e.cyc != cyc || got_e.slot != s ||
                        bus.issue_payload[s*PAYLOAD_W +: PAYLOAD_W] !== got_e.pl ||
                        bus.issue_dest_pr[s*PR_W +: PR_W] !== got_e.dest) begin
                        bad++;
                        $display("FAIL issue cyc=%0d slot=%0d got pl=%0h dest=%0d want cyc=%0d slot=%0d pl=%0h dest=%0d",
                                 cyc, s, bus.issue_payload[s*PAYLOAD_W +: PAYLOAD_W],
                                 bus.issue_dest_pr[s*PR_W +: PR_W],
                                 got_e.cyc, got_e.slot, got_e.pl, got_e.dest);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        logic [63:0] id;
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #1;
        check("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("reset_free_count", 64'(bus.free_count), 64'd16);
        check("reset_struct_stall", 64'(bus.struct_stall), 64'd0);
        reset = 1'b0;

        // Basic 3-lane dispatch, all sources ready
        c0 = cyc;
        lane(2, 6'd1, 6'd10, 1'b1, 6'd11, 1'b1, 64'd4);
        lane(1, 6'd2, 6'd10, 1'b1, 6'd11, 1'b1, 64'd8);
        lane(0, 6'd3, 6'd10, 1'b1, 6'd11, 1'b1, 64'd12);
        push(c0 + 1, 0, 64'd4, 6'd1);
        push(c0 + 1, 1, 64'd8, 6'd2);
        push(c0 + 2, 0, 64'd12, 6'd3);
        tick();
        check("basic_free_13", 64'(bus.free_count), 64'd13);
        tick();
        check("basic_free_15", 64'(bus.free_count), 64'd15);
        tick();
        check("basic_free_16", 64'(bus.free_count), 64'd16);

        // Fill with never-ready entries (src1 = 40)
        for (int unsigned r = 0; r < 5; r++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                id = 64'(100 + 3*r + (2 - k));
                lane(k, id[PR_W-1:0], 6'd40, 1'b0, 6'd41, 1'b1, id);
            end
            tick();
        end
        check("fill_free_1", 64'(bus.free_count), 64'd1);
        check("fill_stall_011", 64'(bus.struct_stall), 64'h3);
        lane(2, 6'd51, 6'd40, 1'b0, 6'd41, 1'b1, 64'd115);
        lane(1, 6'd52, 6'd40, 1'b0, 6'd41, 1'b1, 64'd116);
        lane(0, 6'd53, 6'd40, 1'b0, 6'd41, 1'b1, 64'd117);
        tick();
        check("full_free_0", 64'(bus.free_count), 64'd0);
        check("full_stall_111", 64'(bus.struct_stall), 64'h7);
        // Ready dispatch while full must be dropped
        lane(2, 6'd60, 6'd0, 1'b1, 6'd0, 1'b1, 64'd999);
        lane(1, 6'd61, 6'd0, 1'b1, 6'd0, 1'b1, 64'd998);
        lane(0, 6'd62, 6'd0, 1'b1, 6'd0, 1'b1, 64'd997);
        tick();
        check("full_hold_free_0", 64'(bus.free_count), 64'd0);
        // Wake all 16; they drain two per cycle, oldest first
        c0 = cyc;
        cdb(0, 6'd40);
        for (int unsigned i = 0; i < 16; i++) begin
            id = 64'(100 + i);
            if (i == 15) push(c0 + 1 + i/2, i % 2, 64'd115, 6'd51);
            else         push(c0 + 1 + i/2, i % 2, id, id[PR_W-1:0]);
        end
        tick();
        check("drain_free_still_0", 64'(bus.free_count), 64'd0);
        repeat (8) tick();
        check("drain_free_16", 64'(bus.free_count), 64'd16);

        // Resident wakeup via cdb channel 1
        lane(1, 6'd20, 6'd7, 1'b0, 6'd8, 1'b1, 64'd300);
        tick();
        #1;
        check("wake_wait_no_issue", 64'(bus.issue_valid), 64'd0);
        check("wake_wait_free_15", 64'(bus.free_count), 64'd15);
        c0 = cyc;
        cdb(1, 6'd7);
        push(c0 + 1, 0, 64'd300, 6'd20);
        tick();
        tick();

        // Dispatch-time bypass on cdb channel 2; src2 is the zero register
        c0 = cyc;
        lane(0, 6'd21, 6'd9, 1'b0, 6'd0, 1'b0, 64'd301);
        cdb(2, 6'd9);
        push(c0 + 1, 0, 64'd301, 6'd21);
        tick();
        tick();
        check("bypass_free_16", 64'(bus.free_count), 64'd16);

        // Backpressure with three entries of different ages
        lane(0, 6'd30, 6'd0, 1'b1, 6'd0, 1'b1, 64'd400);
        bus.issue_stall = 1'b1;
        tick();
        lane(2, 6'd31, 6'd0, 1'b1, 6'd0, 1'b1, 64'd401);
        bus.issue_stall = 1'b1;
        #1;
        check("stall_iv_a", 64'(bus.issue_valid), 64'd0);
        tick();
        lane(1, 6'd32, 6'd0, 1'b1, 6'd0, 1'b1, 64'd402);
        bus.issue_stall = 1'b1;
        #1;
        check("stall_iv_b", 64'(bus.issue_valid), 64'd0);
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            bus.issue_stall = 1'b1;
            #1;
            check("stall_iv_full", 64'(bus.issue_valid), 64'd0);
            check("stall_free_13", 64'(bus.free_count), 64'd13);
        end
        tick();
        c0 = cyc;
        push(c0, 0, 64'd400, 6'd30);
        push(c0, 1, 64'd401, 6'd31);
        push(c0 + 1, 0, 64'd402, 6'd32);
        tick();
        tick();
        check("stall_end_free_16", 64'(bus.free_count), 64'd16);

        // Squash with 10 resident entries and a same-cycle dispatch
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned k = 0; k < 3; k++) lane(k, 6'd33, 6'd50, 1'b0, 6'd0, 1'b1, 64'd500);
            tick();
        end
        lane(2, 6'd34, 6'd0, 1'b1, 6'd0, 1'b1, 64'd600);
        tick();
        check("presquash_free_6", 64'(bus.free_count), 64'd6);
        bus.squash = 1'b1;
        lane(2, 6'd35, 6'd0, 1'b1, 6'd0, 1'b1, 64'd700);
        lane(1, 6'd36, 6'd0, 1'b1, 6'd0, 1'b1, 64'd701);
        lane(0, 6'd37, 6'd0, 1'b1, 6'd0, 1'b1, 64'd702);
        cdb(0, 6'd50);
        #1;
        check("squash_iv_0", 64'(bus.issue_valid), 64'd0);
        tick();
        check("squash_free_16", 64'(bus.free_count), 64'd16);
        check("squash_stall_0", 64'(bus.struct_stall), 64'd0);
        repeat (3) tick();
        check("squash_free_16_later", 64'(bus.free_count), 64'd16);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
